cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 159 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues ALU and LSB results in per-source FIFOs and
// broadcasts at most one per cycle, alternating between sources under contention.
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              alu_s,
  input  logic [ROB_W-1:0]  alu_reorder,
  input  logic [DATA_W-1:0] alu_value,
  input  logic              alu_jump_s,
  input  logic [DATA_W-1:0] alu_jump,
  input  logic              lsb_s,
  input  logic [ROB_W-1:0]  lsb_reorder,
  input  logic [DATA_W-1:0] lsb_value,
  output logic              alu_full,
  output logic              lsb_full,
  output logic              cdb_s,
  output logic              cdb_src,
  output logic [ROB_W-1:0]  cdb_reorder,
  output logic [DATA_W-1:0] cdb_value,
  output logic              cdb_jump_s,
  output logic [DATA_W-1:0] cdb_jump,
  output logic              overflow
);
  localparam int   PW      = $clog2(DEPTH);
  localparam int   CW      = PW + 1;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  typedef struct packed {
    logic [ROB_W-1:0]  reorder;
    logic [DATA_W-1:0] value;
    logic              jump_s;
    logic [DATA_W-1:0] jump;
  } entry_t;

  entry_t            in_e   [2];
  entry_t            cand_e [2];
  entry_t            gnt_e;
  logic [1:0]        in_v;
  logic [1:0]        cand;
  logic [1:0]        grant;
  logic [1:0]        drop;
  logic [1:0]        full;
  logic              advance;
  logic              last_src_q, last_src_d;
  logic              cdb_s_q, cdb_src_q, cdb_jump_s_q, overflow_q;
  logic [ROB_W-1:0]  cdb_reorder_q;
  logic [DATA_W-1:0] cdb_value_q, cdb_jump_q;

  // Index 0 is the ALU source, index 1 the LSB; LSB entries carry no jump.
  assign in_v    = {lsb_s, alu_s};
  assign in_e[0] = '{reorder: alu_reorder, value: alu_value, jump_s: alu_jump_s, jump: alu_jump};
  assign in_e[1] = '{reorder: lsb_reorder, value: lsb_value, jump_s: 1'b0, jump: {DATA_W{1'b0}}};
  assign advance = rdy && !clr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    entry_t        mem [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q;
    logic          pop, push_req, push;

    // A queued head always goes first; the live input only bypasses an empty FIFO.
    assign cand[gi]   = (cnt_q != '0) || in_v[gi];
    assign cand_e[gi] = (cnt_q != '0) ? mem[head_q] : in_e[gi];
    assign pop        = grant[gi] && (cnt_q != '0);
    assign push_req   = in_v[gi] && !(grant[gi] && (cnt_q == '0));
    assign drop[gi]   = push_req && (cnt_q == CW'(DEPTH)) && !pop;
    assign push       = push_req && !drop[gi];
    assign cnt_d      = cnt_q + CW'(push) - CW'(pop);
    assign full[gi]   = full_q;

    always_ff @(posedge clk) begin
      if (rst && advance && push) begin
        mem[tail_q] <= in_e[gi];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
        full_q <= 1'b0;
      end else if (rdy) begin
        if (clr) begin
          head_q <= '0;
          tail_q <= '0;
          cnt_q  <= '0;
          full_q <= 1'b0;
        end else begin
          if (pop)  head_q <= head_q + PW'(1);
          if (push) tail_q <= tail_q + PW'(1);
          cnt_q  <= cnt_d;
          // One slot stays free for a result already in flight when the stall lands.
          full_q <= (cnt_d >= CW'(DEPTH - 1));
        end
      end
    end
  end

  always_comb begin
    grant      = cand;
    last_src_d = last_src_q;
    if (&cand) begin
      grant      = (last_src_q == SRC_LSB) ? 2'b01 : 2'b10;
      last_src_d = ~last_src_q;
    end
  end

  assign gnt_e = grant[1] ? cand_e[1] : cand_e[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      cdb_s_q       <= 1'b0;
      cdb_src_q     <= SRC_ALU;
      cdb_reorder_q <= '0;
      cdb_value_q   <= '0;
      cdb_jump_s_q  <= 1'b0;
      cdb_jump_q    <= '0;
      overflow_q    <= 1'b0;
      last_src_q    <= SRC_LSB;
    end else if (rdy) begin
      if (clr) begin
        cdb_s_q      <= 1'b0;
        cdb_jump_s_q <= 1'b0;
        last_src_q   <= SRC_LSB;
      end else begin
        cdb_s_q      <= |grant;
        cdb_jump_s_q <= 1'b0;
        last_src_q   <= last_src_d;
        if (|grant) begin
          cdb_src_q     <= grant[1];
          cdb_reorder_q <= gnt_e.reorder;
          cdb_value_q   <= gnt_e.value;
          cdb_jump_s_q  <= gnt_e.jump_s;
          cdb_jump_q    <= gnt_e.jump;
        end
        if (|drop) overflow_q <= 1'b1;
      end
    end
  end

  assign alu_full    = full[0];
  assign lsb_full    = full[1];
  assign cdb_s       = cdb_s_q;
  assign cdb_src     = cdb_src_q;
  assign cdb_reorder = cdb_reorder_q;
  assign cdb_value   = cdb_value_q;
  assign cdb_jump_s  = cdb_jump_s_q;
  assign cdb_jump    = cdb_jump_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter (DATA_W=32, ROB_W=4, DEPTH=4),
// plus a hand-written reset-in-mid-burst sequence.
module tb_cdb_arbiter;
  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        alu_s, alu_jump_s, lsb_s;
  logic [3:0]  alu_reorder, lsb_reorder;
  logic [31:0] alu_value, alu_jump, lsb_value;
  logic        alu_full, lsb_full, cdb_s, cdb_src, cdb_jump_s, overflow;
  logic [3:0]  cdb_reorder;
  logic [31:0] cdb_value, cdb_jump;

  always #5 clk = ~clk;

  cdb_arbiter #(.DATA_W(32), .ROB_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .alu_s(alu_s), .alu_reorder(alu_reorder), .alu_value(alu_value),
    .alu_jump_s(alu_jump_s), .alu_jump(alu_jump),
    .lsb_s(lsb_s), .lsb_reorder(lsb_reorder), .lsb_value(lsb_value),
    .alu_full(alu_full), .lsb_full(lsb_full),
    .cdb_s(cdb_s), .cdb_src(cdb_src), .cdb_reorder(cdb_reorder), .cdb_value(cdb_value),
    .cdb_jump_s(cdb_jump_s), .cdb_jump(cdb_jump), .overflow(overflow)
  );

  typedef struct {
    logic        r, rd, c;
    logic        a_s;
    logic [3:0]  at;
    logic [31:0] av;
    logic        ajs;
    logic [31:0] aj;
    logic        l_s;
    logic [3:0]  lt;
    logic [31:0] lv;
    logic        es, esrc;
    logic [3:0]  etag;
    logic [31:0] ev;
    logic        ejs;
    logic [31:0] ej;
    logic        eaf, elf, eov;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input int r, rd, c, a_s, at, av, ajs, aj, l_s, lt, lv,
                     input int es, esrc, etag, ev, ejs, ej, eaf, elf, eov);
    vec_t v;
    v.r = (r != 0);     v.rd = (rd != 0);   v.c = (c != 0);
    v.a_s = (a_s != 0); v.at = 4'(at);      v.av = 32'(av);
    v.ajs = (ajs != 0); v.aj = 32'(aj);
    v.l_s = (l_s != 0); v.lt = 4'(lt);      v.lv = 32'(lv);
    v.es = (es != 0);   v.esrc = (esrc != 0); v.etag = 4'(etag); v.ev = 32'(ev);
    v.ejs = (ejs != 0); v.ej = 32'(ej);
    v.eaf = (eaf != 0); v.elf = (elf != 0); v.eov = (eov != 0);
    vecs.push_back(v);
  endtask

  task automatic set_in(input int r, rd, c, a_s, at, av, ajs, aj, l_s, lt, lv);
    rst = (r != 0); rdy = (rd != 0); clr = (c != 0);
    alu_s = (a_s != 0); alu_reorder = 4'(at); alu_value = 32'(av);
    alu_jump_s = (ajs != 0); alu_jump = 32'(aj);
    lsb_s = (l_s != 0); lsb_reorder = 4'(lt); lsb_value = 32'(lv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // single ALU result after reset
    add(0,1,0, 0,0,0,0,0,       0,0,0,      0,0,0,0,0,0,        0,0,0);
    add(1,1,0, 1,3,'h11,0,0,    0,0,0,      1,0,3,'h11,0,0,     0,0,0);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      0,0,0,0,0,0,        0,0,0);
    // simultaneous results: ALU first, LSB next, then LSB wins the following contention
    add(0,1,0, 0,0,0,0,0,       0,0,0,      0,0,0,0,0,0,        0,0,0);
    add(1,1,0, 1,1,'h21,0,0,    1,2,'h22,   1,0,1,'h21,0,0,     0,0,0);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      1,1,2,'h22,0,0,     0,0,0);
    add(1,1,0, 1,5,'h25,1,'h400, 1,6,'h26,  1,1,6,'h26,0,0,     0,0,0);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      1,0,5,'h25,1,'h400, 0,0,0);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      0,0,0,0,0,0,        0,0,0);
    // sustained traffic on both sources: alternation, full flags, then an LSB drop
    add(0,1,0, 0,0,0,0,0,       0,0,0,      0,0,0,0,0,0,        0,0,0);
    add(1,1,0, 1,0,'hA0,0,0,    1,15,'hB0,  1,0,0,'hA0,0,0,     0,0,0);
    add(1,1,0, 1,1,'hA1,0,0,    1,14,'hB1,  1,1,15,'hB0,0,0,    0,0,0);
    add(1,1,0, 1,2,'hA2,0,0,    1,13,'hB2,  1,0,1,'hA1,0,0,     0,0,0);
    add(1,1,0, 1,3,'hA3,1,'h3000, 1,12,'hB3, 1,1,14,'hB1,0,0,   0,0,0);
    add(1,1,0, 1,4,'hA4,0,0,    1,11,'hB4,  1,0,2,'hA2,0,0,     0,1,0);
    add(1,1,0, 1,5,'hA5,0,0,    1,10,'hB5,  1,1,13,'hB2,0,0,    1,1,0);
    add(1,1,0, 1,6,'hA6,0,0,    1,9,'hB6,   1,0,3,'hA3,1,'h3000, 1,1,0);
    add(1,1,0, 1,7,'hA7,0,0,    1,8,'hB7,   1,1,12,'hB3,0,0,    1,1,0);
    add(1,1,0, 1,8,'hA8,0,0,    1,7,'hB8,   1,0,4,'hA4,0,0,     1,1,1);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      1,1,11,'hB4,0,0,    1,1,1);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      1,0,5,'hA5,0,0,     1,1,1);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      1,1,10,'hB5,0,0,    1,0,1);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      1,0,6,'hA6,0,0,     0,0,1);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      1,1,9,'hB6,0,0,     0,0,1);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      1,0,7,'hA7,0,0,     0,0,1);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      1,1,8,'hB7,0,0,     0,0,1);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      1,0,8,'hA8,0,0,     0,0,1);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      0,0,0,0,0,0,        0,0,1);
    add(0,1,0, 0,0,0,0,0,       0,0,0,      0,0,0,0,0,0,        0,0,0);
    // flush with three entries queued; afterwards ALU has priority again
    add(1,1,0, 1,1,'hC1,0,0,    1,2,'hD2,   1,0,1,'hC1,0,0,     0,0,0);
    add(1,1,0, 1,3,'hC3,1,'h300, 1,4,'hD4,  1,1,2,'hD2,0,0,     0,0,0);
    add(1,1,0, 1,5,'hC5,0,0,    1,6,'hD6,   1,0,3,'hC3,1,'h300, 0,0,0);
    add(1,1,1, 1,7,'hC7,1,'h77, 1,8,'hD8,   0,0,0,0,0,0,        0,0,0);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      0,0,0,0,0,0,        0,0,0);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      0,0,0,0,0,0,        0,0,0);
    add(1,1,0, 1,9,'hC9,0,0,    1,10,'hDA,  1,0,9,'hC9,0,0,     0,0,0);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      1,1,10,'hDA,0,0,    0,0,0);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      0,0,0,0,0,0,        0,0,0);
    // rdy low for three cycles freezes everything, including clr and inputs
    add(0,1,0, 0,0,0,0,0,       0,0,0,      0,0,0,0,0,0,        0,0,0);
    add(1,1,0, 1,1,'hE1,0,0,    1,2,'hF2,   1,0,1,'hE1,0,0,     0,0,0);
    add(1,1,0, 1,3,'hE3,1,'h333, 1,4,'hF4,  1,1,2,'hF2,0,0,     0,0,0);
    add(1,0,0, 1,11,'hEB,0,0,   1,12,'hFC,  1,1,2,'hF2,0,0,     0,0,0);
    add(1,0,1, 1,11,'hEB,0,0,   1,12,'hFC,  1,1,2,'hF2,0,0,     0,0,0);
    add(1,0,0, 0,0,0,0,0,       0,0,0,      1,1,2,'hF2,0,0,     0,0,0);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      1,0,3,'hE3,1,'h333, 0,0,0);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      1,1,4,'hF4,0,0,     0,0,0);
    add(1,1,0, 0,0,0,0,0,       0,0,0,      0,0,0,0,0,0,        0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      set_in(int'(vecs[i].r), int'(vecs[i].rd), int'(vecs[i].c), int'(vecs[i].a_s), int'(vecs[i].at),
             int'(vecs[i].av), int'(vecs[i].ajs), int'(vecs[i].aj), int'(vecs[i].l_s),
             int'(vecs[i].lt), int'(vecs[i].lv));
      tick();
      check("ctrl", i, 80'({cdb_s, cdb_jump_s, alu_full, lsb_full, overflow}),
            80'({vecs[i].es, vecs[i].ejs, vecs[i].eaf, vecs[i].elf, vecs[i].eov}));
      if (vecs[i].es || !vecs[i].r)
        check("data", i, 80'({cdb_src, cdb_reorder, cdb_value, cdb_jump}),
              80'({vecs[i].esrc, vecs[i].etag, vecs[i].ev, vecs[i].ej}));
      $display("vec %0d: cdb_s=%b src=%b tag=%0d value=%h jump_s=%b full=%b%b ovf=%b",
               i, cdb_s, cdb_src, cdb_reorder, cdb_value, cdb_jump_s, alu_full, lsb_full, overflow);
    end

    // reset in the middle of a burst discards everything queued
    @(negedge clk); set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    @(negedge clk); set_in(1, 1, 0, 1, 1, 'h51, 0, 0, 1, 2, 'h62); tick();
    check("burst_first", 100, 80'({cdb_s, cdb_src, cdb_reorder}), 80'({1'b1, 1'b0, 4'd1}));
    @(negedge clk); set_in(1, 1, 0, 1, 3, 'h53, 0, 0, 1, 4, 'h64); tick();
    check("burst_second", 101, 80'({cdb_s, cdb_src, cdb_reorder}), 80'({1'b1, 1'b1, 4'd2}));
    @(negedge clk); set_in(0, 1, 0, 1, 5, 'h55, 1, 'h99, 1, 6, 'h66); tick();
    check("reset_mid", 102, 80'({cdb_s, cdb_src, cdb_reorder, cdb_value, cdb_jump_s, cdb_jump,
                                alu_full, lsb_full, overflow}), 80'(0));
    $display("reset mid-burst: cdb_s=%b tag=%0d", cdb_s, cdb_reorder);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      check("after_reset_idle", 103 + k, 80'(cdb_s), 80'(0));
      $display("post-reset idle %0d: cdb_s=%b", k, cdb_s);
    end
    @(negedge clk); set_in(1, 1, 0, 1, 7, 'h57, 0, 0, 0, 0, 0); tick();
    check("after_reset_new", 106, 80'({cdb_s, cdb_src, cdb_reorder, cdb_value}),
          80'({1'b1, 1'b0, 4'd7, 32'h57}));
    $display("post-reset result: cdb_s=%b tag=%0d value=%h", cdb_s, cdb_reorder, cdb_value);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
